// File: rtl/fifo_rptr_empty.sv
// Read-side pointer/empty controller for an asynchronous FIFO (read clock domain).
// Latency: accepted read -> rdata/rvalid after 1 edge; write pointer -> empty/level after SYNC_STAGES+1 edges.
// Backpressure: reads are refused while rempty is high (runderflow pulses); empty is pessimistic.
module fifo_rptr_empty #(
   parameter int DATA_SIZE        = 8,
   parameter int ADDR_SIZE        = 4,
   parameter int SYNC_STAGES      = 2,
   parameter int ALMOST_EMPTY_LVL = 2
) (
   input  logic                 rclk,
   input  logic                 rrst,
   input  logic                 rinc,
   input  logic [ADDR_SIZE:0]   wptr_async,
   input  logic [DATA_SIZE-1:0] mem_rdata,
   output logic [ADDR_SIZE-1:0] raddr,
   output logic [ADDR_SIZE:0]   rptr,
   output logic [DATA_SIZE-1:0] rdata,
   output logic                 rvalid,
   output logic                 rempty,
   output logic                 ralmost_empty,
   output logic [ADDR_SIZE:0]   rlevel,
   output logic                 runderflow
);

   localparam int PW = ADDR_SIZE + 1;
   localparam logic [ADDR_SIZE:0] AE_LVL = PW'(ALMOST_EMPTY_LVL);
   localparam logic [ADDR_SIZE:0] ONE    = PW'(1);

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
      logic [ADDR_SIZE:0] b;
      b[ADDR_SIZE] = g[ADDR_SIZE];
      for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [ADDR_SIZE:0]   sync_q [SYNC_STAGES];
   logic [ADDR_SIZE:0]   sync_d [SYNC_STAGES];
   logic [ADDR_SIZE:0]   rbin_q,  rbin_d;
   logic [ADDR_SIZE:0]   rptr_q,  rptr_d;
   logic [DATA_SIZE-1:0] rdata_q, rdata_d;
   logic                 rvalid_q, rvalid_d;
   logic                 rempty_q, rempty_d;
   logic                 ralmost_empty_q, ralmost_empty_d;
   logic [ADDR_SIZE:0]   rlevel_q, rlevel_d;
   logic                 runderflow_q, runderflow_d;

   // Combinational helpers
   logic [ADDR_SIZE:0]   rq_wptr;
   logic [ADDR_SIZE:0]   wbin_s;
   logic                 accept;
   logic [ADDR_SIZE:0]   rbinnext;
   logic [ADDR_SIZE:0]   rgraynext;

   // Pure shift chain: the first stage samples the asynchronous pointer, no logic in between.
   always_comb begin
      sync_d[0] = wptr_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // Synchronizer flops for the incoming Gray write pointer.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
      end
   end

   // Pointer arithmetic: only a read against a non-empty FIFO moves the pointer.
   always_comb begin
      rq_wptr   = sync_q[SYNC_STAGES-1];
      wbin_s    = gray2bin(rq_wptr);
      accept    = rinc & ~rempty_q;
      rbinnext  = accept ? (rbin_q + ONE) : rbin_q;
      rgraynext = rbinnext ^ (rbinnext >> 1);
   end

   // Next-state: status is computed from the post-read pointer so the edge that
   // consumes the last word also raises empty.
   always_comb begin
      rbin_d          = rbinnext;
      rptr_d          = rgraynext;
      rempty_d        = (rgraynext == rq_wptr);
      rlevel_d        = wbin_s - rbinnext;
      ralmost_empty_d = (rlevel_d <= AE_LVL);
      rdata_d         = rdata_q;
      rvalid_d        = 1'b0;
      runderflow_d    = rinc & rempty_q;
      if (accept) begin
         rdata_d  = mem_rdata;
         rvalid_d = 1'b1;
      end
   end

   // Read-domain registers; empty and almost-empty come out of reset asserted.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         rbin_q          <= '0;
         rptr_q          <= '0;
         rdata_q         <= '0;
         rvalid_q        <= 1'b0;
         rempty_q        <= 1'b1;
         ralmost_empty_q <= 1'b1;
         rlevel_q        <= '0;
         runderflow_q    <= 1'b0;
      end else begin
         rbin_q          <= rbin_d;
         rptr_q          <= rptr_d;
         rdata_q         <= rdata_d;
         rvalid_q        <= rvalid_d;
         rempty_q        <= rempty_d;
         ralmost_empty_q <= ralmost_empty_d;
         rlevel_q        <= rlevel_d;
         runderflow_q    <= runderflow_d;
      end
   end

   // The memory address is the low bits of the binary pointer, so the head word
   // is always presented on mem_rdata ahead of the read.
   assign raddr         = rbin_q[ADDR_SIZE-1:0];
   assign rptr          = rptr_q;
   assign rdata         = rdata_q;
   assign rvalid        = rvalid_q;
   assign rempty        = rempty_q;
   assign ralmost_empty = ralmost_empty_q;
   assign rlevel        = rlevel_q;
   assign runderflow    = runderflow_q;

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Bench for the FIFO read-side controller: table vectors, corner sequences, random run.
// Reference model counts words written/read as plain integers and delays the write count.
// Inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_fifo_rptr_empty;

   localparam int DW   = 8;
   localparam int AW   = 4;
   localparam int SYNC = 2;
   localparam int AEL  = 2;
   localparam int DEPTH = 1 << AW;

   logic          rclk = 1'b0;
   logic          rrst;
   logic          rinc;
   logic [AW:0]   wptr_async;
   logic [DW-1:0] mem_rdata;
   logic [AW-1:0] raddr;
   logic [AW:0]   rptr;
   logic [DW-1:0] rdata;
   logic          rvalid, rempty, ralmost_empty, runderflow;
   logic [AW:0]   rlevel;

   fifo_rptr_empty #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .SYNC_STAGES(SYNC),
                     .ALMOST_EMPTY_LVL(AEL)) dut (
      .rclk(rclk), .rrst(rrst), .rinc(rinc), .wptr_async(wptr_async),
      .mem_rdata(mem_rdata), .raddr(raddr), .rptr(rptr), .rdata(rdata),
      .rvalid(rvalid), .rempty(rempty), .ralmost_empty(ralmost_empty),
      .rlevel(rlevel), .runderflow(runderflow)
   );

   always #5 rclk = ~rclk;

   // Behavioural memory: combinational read at the DUT's address.
   logic [DW-1:0] mem [DEPTH];
   assign mem_rdata = mem[raddr];

   int total = 0;
   int bad   = 0;

   // Model state: unbounded word counts, history of the write count seen at each edge.
   int            m_w, m_r;
   int            hist[$];
   logic [DW-1:0] dq[$];
   logic          m_empty, m_valid, m_uf;
   logic [DW-1:0] m_rdata;
   int            m_lvl;

   function automatic logic [AW:0] gray(input int n);
      logic [AW:0] b;
      b = (AW+1)'(n);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_w = 0; m_r = 0;
      hist.delete(); dq.delete();
      m_empty = 1'b1; m_valid = 1'b0; m_uf = 1'b0;
      m_rdata = '0; m_lvl = 0;
   endtask

   // One cycle: called at the falling edge, returns at the next falling edge.
   task automatic step(input logic ri, input logic wr, input logic [DW-1:0] wd);
      int r_old, seen;
      r_old   = m_r;
      m_uf    = ri && m_empty;
      m_valid = ri && !m_empty;
      if (m_valid) begin
         m_rdata = dq.pop_front();
         m_r++;
      end
      if (wr && (m_w - r_old) < DEPTH) begin
         mem[m_w % DEPTH] = wd;
         dq.push_back(wd);
         m_w++;
      end
      rinc       = ri;
      wptr_async = gray(m_w);
      hist.push_back(m_w);
      seen    = (hist.size() > SYNC) ? hist[hist.size()-1-SYNC] : 0;
      m_lvl   = seen - m_r;
      m_empty = (m_lvl == 0);
      @(posedge rclk);
      #1;
      chk("rempty", int'(rempty), int'(m_empty));
      chk("ralmost_empty", int'(ralmost_empty), int'(m_lvl <= AEL));
      chk("rlevel", int'(rlevel), m_lvl);
      chk("rvalid", int'(rvalid), int'(m_valid));
      chk("runderflow", int'(runderflow), int'(m_uf));
      chk("raddr", int'(raddr), m_r % DEPTH);
      chk("rptr", int'(rptr), int'(gray(m_r)));
      chk("rdata", int'(rdata), int'(m_rdata));
      @(negedge rclk);
   endtask

   typedef struct {
      logic          ri;
      logic          wr;
      logic [DW-1:0] wd;
      logic          e_empty;
      int            e_lvl;
      logic          e_vld;
      logic          e_uf;
   } vec_t;

   vec_t tbl[17];

   initial begin
      int reads, hd, n;
      logic [AW-1:0] pre_addr;
      logic [AW:0]   pre_ptr;
      logic          msb_seen;
      int addr_log[$];

      tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1}; // read while empty
      tbl[1]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 0, 1'b0, 1'b0}; // first write
      tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0}; // visible two edges later
      tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0}; // single read
      tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1}; // underflow
      tbl[6]  = '{1'b0, 1'b1, 8'h11, 1'b1, 0, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 8'h22, 1'b1, 0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 8'h44, 1'b0, 2, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 3, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 8'h55, 1'b0, 3, 1'b1, 1'b0}; // read + write: level holds
      tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 2, 1'b1, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 2, 1'b1, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 1, 1'b1, 1'b0};
      tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0}; // last word: empty same edge
      tbl[16] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1}; // blocked, no overrun

      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      rrst = 1'b1; rinc = 1'b0; wptr_async = '0;
      model_reset();
      @(negedge rclk);
      @(negedge rclk);
      #1;
      chk("reset_rempty", int'(rempty), 1);
      chk("reset_ralmost", int'(ralmost_empty), 1);
      chk("reset_rlevel", int'(rlevel), 0);
      chk("reset_rptr", int'(rptr), 0);
      @(negedge rclk);
      rrst = 1'b0;

      // Table vectors from reset
      for (int i = 0; i < 17; i++) begin
         step(tbl[i].ri, tbl[i].wr, tbl[i].wd);
         chk("tbl_rempty", int'(rempty), int'(tbl[i].e_empty));
         chk("tbl_rlevel", int'(rlevel), tbl[i].e_lvl);
         chk("tbl_rvalid", int'(rvalid), int'(tbl[i].e_vld));
         chk("tbl_runderflow", int'(runderflow), int'(tbl[i].e_uf));
         if (i == 4 || i == 5) begin
            chk("tbl_rdata_a5", int'(rdata), 8'hA5);
            chk("tbl_rptr_1", int'(rptr), 1);
            chk("tbl_raddr_1", int'(raddr), 1);
         end
      end

      // Asynchronous reset mid-cycle while non-empty
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(i + 8'h60));
      chk("pre_reset_nonempty", int'(rempty), 0);
      @(posedge rclk);
      #2;
      rrst = 1'b1;
      wptr_async = '0;
      #1;
      chk("areset_rempty", int'(rempty), 1);
      chk("areset_ralmost", int'(ralmost_empty), 1);
      chk("areset_rptr", int'(rptr), 0);
      chk("areset_raddr", int'(raddr), 0);
      chk("areset_rlevel", int'(rlevel), 0);
      chk("areset_rvalid", int'(rvalid), 0);
      model_reset();
      @(negedge rclk);
      rrst = 1'b0;

      // Level / almost-empty: five words, then three reads
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h70 + i));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
      chk("lvl5_rlevel", int'(rlevel), 5);
      chk("lvl5_ralmost", int'(ralmost_empty), 0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
      chk("lvl2_rlevel", int'(rlevel), 2);
      chk("lvl2_ralmost", int'(ralmost_empty), 1);
      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00);
      chk("drained", int'(rempty), 1);

      // Wrap: stream 40 words with continuous read requests
      rrst = 1'b1;
      #1;
      model_reset();
      @(negedge rclk);
      rrst = 1'b0;
      reads = 0; msb_seen = 1'b0; n = 0;
      while (reads < 40 && n < 300) begin
         pre_addr = raddr;
         pre_ptr  = rptr;
         step(1'b1, 1'b1, 8'($urandom));
         n++;
         if (rvalid) begin
            addr_log.push_back(int'(pre_addr));
            hd = $countones(pre_ptr ^ rptr);
            reads++;
            chk("wrap_hamming", hd, 1);
            if (reads == 16) begin
               chk("wrap_msb", int'(rptr[AW]), 1);
               msb_seen = 1'b1;
            end
         end
      end
      chk("wrap_reads_done", reads, 40);
      chk("wrap_msb_reached", int'(msb_seen), 1);
      for (int i = 0; i < addr_log.size(); i++) chk("wrap_raddr_seq", addr_log[i], i % DEPTH);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_rptr_empty.md
# fifo_rptr_empty

Read-side controller for the asynchronous FIFO, in the read clock domain. It accepts read requests and synchronizes the Gray-coded write pointer. It drives the memory read address and the Gray-coded read pointer back to the write domain. It generates empty, almost-empty and underflow status. Read data from the combinational memory port is captured into a registered output with a one-cycle valid pulse.

## Interface
- DATA_SIZE, 8, data word width
- ADDR_SIZE, 4, memory address width; depth = 2^ADDR_SIZE
- SYNC_STAGES, 2, flop stages on the incoming write pointer (≥2)
- ALMOST_EMPTY_LVL, 2, ralmost_empty asserts when level ≤ this value

Ports:
- rclk  in  1  read clock; all state on rising edge
- rrst  in  1  reset, asynchronous, active-high
- rinc  in  1  read request
- wptr_async  in  ADDR_SIZE+1  Gray write pointer from write domain (unsynchronized)
- mem_rdata  in  DATA_SIZE  memory read data, combinational from raddr
- raddr  out  ADDR_SIZE  memory read address
- rptr  out  ADDR_SIZE+1  Gray read pointer to write domain, registered
- rdata  out  DATA_SIZE  registered read data
- rvalid  out  1  one-cycle pulse: rdata updated
- rempty  out  1  FIFO empty, registered
- ralmost_empty  out  1  level ≤ ALMOST_EMPTY_LVL, registered
- rlevel  out  ADDR_SIZE+1  words available, as seen from read domain, registered
- runderflow  out  1  one-cycle pulse: rinc while rempty

## Operation
- Reset values:
  - rbin, rptr, rq_wptr chain, raddr, rdata, rlevel = 0
  - rvalid, runderflow = 0
  - rempty, ralmost_empty = 1
- Synchronizer: wptr_async → SYNC_STAGES flops → rq_wptr. No logic between stages.
- wbin_s = gray-to-binary(rq_wptr), combinational.
- accept = rinc & ~rempty.
- rbinnext = rbin + accept, modulo 2^(ADDR_SIZE+1); rgraynext = rbinnext ^ (rbinnext >> 1).
- Each edge:
  - rbin ← rbinnext; rptr ← rgraynext
  - rempty ← (rgraynext == rq_wptr)
  - rlevel ← (wbin_s − rbinnext) mod 2^(ADDR_SIZE+1)
  - ralmost_empty ← that same difference ≤ ALMOST_EMPTY_LVL
- raddr = rbin[ADDR_SIZE-1:0], so the memory always presents the head word.
- On accept: rdata ← mem_rdata (head word at current raddr); rvalid ← 1. Otherwise rdata holds and rvalid ← 0.
- rinc while rempty:
  - no pointer movement, rdata holds, rvalid 0
  - runderflow ← 1 for one cycle
- Wrap-around:
  - rbin rolls from 2^(ADDR_SIZE+1)−1 to 0
  - raddr rolls from DEPTH−1 to 0
  - the MSB toggle distinguishes laps; rptr changes exactly one bit per read
- Empty is pessimistic: write-side updates are seen SYNC_STAGES cycles late. The block never reports a word that has not been written.

## Timing
- Read latency: rinc accepted at edge N → rdata/rvalid valid after edge N; rvalid low after edge N+1 unless another accept occurs.
- Back-to-back: rinc held high with data available gives one word per cycle. rempty rises on the same edge that consumes the last word, so the next rinc is blocked with no overrun.
- Empty release: wptr_async stable before edge E → rq_wptr updates after edge E+SYNC_STAGES−1 → rempty, rlevel and ralmost_empty update after edge E+SYNC_STAGES.
- Simultaneous read and write-pointer advance in the same cycle: both are reflected in the next rempty/rlevel. The level stays unchanged if the write pointer advances by one.
- Async reset mid-operation: all outputs go to reset values immediately, without waiting for a clock edge. After release, the first accept requires rq_wptr ≠ 0.
- rptr is glitch-free (flop output only), so it is safe to synchronize in the write domain.

## Test plan
- Reset:
  - assert rrst mid-cycle with rempty=0 → immediately rempty=1, ralmost_empty=1, rptr=0, raddr=0, rlevel=0, rvalid=0
- Empty release:
  - wptr_async 0→1 (Gray) before edge E, SYNC_STAGES=2 → rempty falls after edge E+2, rlevel=1, ralmost_empty=1
- Single read:
  - mem_rdata=0xA5, rinc one cycle → next cycle rdata=0xA5, rvalid=1 for one cycle
  - rptr=1, raddr=1, rempty=1
- Underflow:
  - rinc=1 with rempty=1 → runderflow pulses one cycle; rptr, raddr and rdata unchanged
- Level/almost-empty:
  - wptr_async=Gray(5), rbin=0 → rlevel=5, ralmost_empty=0
  - after 3 reads → rlevel=2, ralmost_empty=1
- Wrap:
  - stream 40 words with continuous rinc → raddr sequence 0..15,0..15,0..7
  - rptr MSB toggles after read 16; rptr Hamming distance 1 per read
  - rdata matches the write order exactly
